// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared UART receive constants, FSM encoding and tick divisor formula
package uart_rx_fifo_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  function automatic int tick_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy level and synchronous active-low reset
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level[AW];
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a show-ahead byte FIFO
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD = 115200,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_err,
  output logic                     overflow
);
  localparam int DIV = tick_div(CLK_FREQ, BAUD);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  logic rx_meta, rxs, armed, os_tick, mid, last, push, full, empty;
  logic [DW-1:0] div_cnt;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  rx_state_t state, state_nx;
  assign os_tick = div_cnt == DW'(DIV-1);
  assign mid = os_cnt == 4'(MID_SAMPLE);
  assign last = os_cnt == 4'(OVERSAMPLE-1);
  assign rd_valid = ~empty;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs <= 1'b1;
      div_cnt <= '0;
      armed <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs <= rx_meta;
      div_cnt <= os_tick ? '0 : div_cnt + 1'b1;
      armed <= armed | (os_tick & rxs);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      os_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
    end else if (os_tick) begin
      state <= state_nx;
      os_cnt <= state_nx != state ? '0 : os_cnt + 1'b1;
      if (state == START) bit_cnt <= '0;
      if (state == DATA && last) begin
        shift[bit_cnt] <= rxs;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = armed && !rxs ? START : IDLE;
      START:   state_nx = mid ? (rxs ? IDLE : DATA) : START;
      DATA:    state_nx = last && bit_cnt == 3'(DATA_BITS-1) ? STOP : DATA;
      STOP:    state_nx = last ? (rxs ? IDLE : BREAK) : STOP;
      BREAK:   state_nx = rxs ? IDLE : BREAK;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    push = os_tick && state == STOP && last && rxs;
    frame_err = os_tick && state == STOP && last && !rxs;
    overflow = push && full && !(rd_en && !empty);
  end
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(rd_en),
    .wdata(shift),
    .rdata(rd_data),
    .empty(empty),
    .full(full),
    .level(level)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table-driven checks of the UART receive FIFO
module tb_uart_rx_fifo;
  localparam int BAUD = 115200;
  localparam int DIV = 4;
  localparam int CLK_FREQ = DIV * 16 * BAUD;
  localparam int DEPTH = 16;
  localparam int BIT = DIV * 16;
  localparam int NOM = BIT * 100;
  localparam int SLOW = BIT * 102;
  logic clk = 1'b0, rst_n = 1'b1, rx = 1'b1, rd_en = 1'b0;
  logic [7:0] rd_data;
  logic rd_valid, frame_err, overflow;
  logic [4:0] level;
  int checks = 0, errors = 0, fe_cnt = 0, ov_cnt = 0, cyc = 0, start_cyc = -1, push_off = 0;
  typedef struct {
    logic [7:0] data;
    int lvl;
    logic [7:0] head;
    int ov;
  } vec_t;
  vec_t fill[17];
  vec_t drain[16];
  logic [7:0] slow_bytes[3];
  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .level(level),
    .frame_err(frame_err),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overflow) ov_cnt++;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pop();
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input int bt100);
    logic [9:0] f;
    int t;
    f = {stop, d, 1'b0};
    @(posedge clk);
    #1;
    while (cyc % DIV != 0) begin
      @(posedge clk);
      #1;
    end
    start_cyc = cyc;
    t = 0;
    for (int k = 0; k < 10; k++) begin
      rx = f[k];
      while (t < ((k + 1) * bt100) / 100) begin
        @(posedge clk);
        #1;
        t++;
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 17; i++) fill[i] = '{8'(i), i < 16 ? i + 1 : 16, 8'h00, i < 16 ? 0 : 1};
    for (int i = 0; i < 16; i++) drain[i] = '{8'h00, 15 - i, i < 15 ? 8'(i + 1) : 8'h11, 0};
    slow_bytes = '{8'hE7, 8'h18, 8'h5A};
    #20 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    wait_clks(2);
    chk("reset_level", int'(level), 0);
    chk("reset_valid", int'(rd_valid), 0);
    chk("reset_data", int'(rd_data), 0);
    chk("reset_flags", int'({frame_err, overflow}), 0);
    wait_clks(2 * BIT);
    send(8'h55, 1'b1, NOM);
    send(8'h36, 1'b1, NOM);
    wait_clks(BIT);
    chk("loop_level", int'(level), 2);
    chk("loop_head0", int'(rd_data), 'h55);
    pop();
    chk("loop_head1", int'(rd_data), 'h36);
    pop();
    chk("loop_empty", int'(level), 0);
    rx = 1'b0;
    wait_clks(5 * DIV);
    rx = 1'b1;
    wait_clks(2 * BIT);
    chk("glitch_level", int'(level), 0);
    chk("glitch_fe", fe_cnt, 0);
    send(8'h81, 1'b1, NOM);
    wait_clks(BIT);
    chk("glitch_after", int'(rd_data), 'h81);
    pop();
    send(8'hA5, 1'b0, NOM);
    wait_clks(3 * BIT);
    chk("frame_fe", fe_cnt, 1);
    chk("frame_level", int'(level), 0);
    rx = 1'b1;
    wait_clks(BIT);
    send(8'h3C, 1'b1, NOM);
    wait_clks(BIT);
    chk("frame_next_level", int'(level), 1);
    chk("frame_next_data", int'(rd_data), 'h3C);
    chk("frame_fe_once", fe_cnt, 1);
    pop();
    for (int i = 0; i < 17; i++) begin
      if (i == 15) begin
        start_cyc = -1;
        fork
          send(fill[i].data, 1'b1, NOM);
          begin
            int n = 0;
            while (start_cyc < 0) begin
              @(posedge clk);
              #1;
            end
            while (level != 5'd16 && n < 2000) begin
              @(posedge clk);
              #1;
              n++;
            end
            push_off = cyc - start_cyc;
          end
        join
      end else send(fill[i].data, 1'b1, NOM);
      wait_clks(4);
      chk($sformatf("fill%0d_level", i), int'(level), fill[i].lvl);
      chk($sformatf("fill%0d_head", i), int'(rd_data), int'(fill[i].head));
      chk($sformatf("fill%0d_ovf", i), ov_cnt, fill[i].ov);
    end
    start_cyc = -1;
    fork
      send(8'h11, 1'b1, NOM);
      begin
        while (start_cyc < 0) begin
          @(posedge clk);
          #1;
        end
        while (cyc < start_cyc + push_off - 1) begin
          @(posedge clk);
          #1;
        end
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
      end
    join
    wait_clks(4);
    chk("simul_level", int'(level), 16);
    chk("simul_ovf", ov_cnt, 1);
    chk("simul_head", int'(rd_data), 'h01);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_data", i), int'(rd_data), int'(drain[i].head));
      pop();
      chk($sformatf("drain%0d_level", i), int'(level), drain[i].lvl);
    end
    chk("drain_valid", int'(rd_valid), 0);
    rx = 1'b0;
    wait_clks(BIT);
    rx = 1'b1;
    wait_clks(BIT);
    rx = 1'b0;
    wait_clks(BIT);
    rx = 1'b1;
    wait_clks(BIT);
    rx = 1'b0;
    wait_clks(BIT / 2);
    rst_n = 1'b0;
    wait_clks(1);
    rst_n = 1'b1;
    wait_clks(4 * BIT);
    chk("rst_mid_level", int'(level), 0);
    chk("rst_mid_valid", int'(rd_valid), 0);
    chk("rst_mid_flags", fe_cnt * 16 + ov_cnt, 16 + 1);
    rx = 1'b1;
    wait_clks(2 * BIT);
    send(8'hC3, 1'b1, NOM);
    wait_clks(BIT);
    chk("rst_next_level", int'(level), 1);
    chk("rst_next_data", int'(rd_data), 'hC3);
    pop();
    for (int i = 0; i < 3; i++) send(slow_bytes[i], 1'b1, SLOW);
    wait_clks(BIT);
    chk("slow_level", int'(level), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("slow%0d_data", i), int'(rd_data), int'(slow_bytes[i]));
      pop();
    end
    chk("final_fe", fe_cnt, 1);
    chk("final_ovf", ov_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
